// File: rtl/acc_unit.sv
// 6-bit signed accumulator around the shared ripple adder; valid/ready in and out.
// Optional clamp on ADD/SUB overflow: define ACC_UNIT_SATURATE_EN.

module adder (
  input  logic [5:0] A,
  input  logic [5:0] B,
  output logic [5:0] C,
  output logic       overflow
);

  always_comb begin
    logic cy;
    cy = 1'b0;
    C  = '0;
    for (int i = 0; i < 6; i++) begin
      C[i] = A[i] ^ B[i] ^ cy;
      cy   = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
    end
  end

  assign overflow = (A[5] ~^ B[5]) & (C[5] ^ A[5]);

endmodule

module acc_unit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             sticky_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NEG  = 2'd1,
    EXEC = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef ACC_UNIT_SATURATE_EN
  localparam logic [WIDTH-1:0] S_MAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] neg_q, neg_d;
  logic             neg_ovf_q, neg_ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             add_ovf;
  logic [WIDTH-1:0] res;
  logic             ovf;

  adder u_adder (
    .A        (add_a),
    .B        (add_b),
    .C        (sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      data_q     <= '0;
      neg_q      <= '0;
      neg_ovf_q  <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      neg_q      <= neg_d;
      neg_ovf_q  <= neg_ovf_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (in_op == OP_SUB) ? NEG : EXEC;
        end
      end
      NEG:  state_d = EXEC;
      EXEC: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == OUT);
    out_data   = out_data_q;
    out_ovf    = out_ovf_q;
    sticky_ovf = sticky_q;
  end

  // Adder is shared: negation in NEG, accumulate in EXEC.
  always_comb begin
    add_a = acc_q;
    add_b = (op_q == OP_SUB) ? neg_q : data_q;
    if (state_q == NEG) begin
      add_a = ~data_q;
      add_b = ONE;
    end
  end

  always_comb begin
    op_d       = op_q;
    data_d     = data_q;
    neg_d      = neg_q;
    neg_ovf_d  = neg_ovf_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    sticky_d   = sticky_q;
    res        = acc_q;
    ovf        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = in_op;
          data_d = in_data;
        end
      end
      NEG: begin
        neg_d     = sum;
        neg_ovf_d = add_ovf;
      end
      EXEC: begin
        unique case (1'b1)
          (op_q == OP_ADD): begin
            res = sum;
            ovf = add_ovf;
          end
          (op_q == OP_SUB): begin
            res = sum;
            // Negating -32 wraps; the op overflows iff acc >= 0.
            ovf = neg_ovf_q ? ~acc_q[WIDTH-1] : add_ovf;
          end
          (op_q == OP_LD): begin
            res = data_q;
          end
          default: begin
            res = '0;
          end
        endcase
`ifdef ACC_UNIT_SATURATE_EN
        if (ovf) begin
          res = sum[WIDTH-1] ? S_MAX : S_MIN;
        end
`endif
        acc_d      = res;
        out_data_d = res;
        out_ovf_d  = ovf;
        sticky_d   = (op_q == OP_CLR) ? 1'b0 : (sticky_q | ovf);
      end
      default: ;
    endcase
  end

endmodule
